pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage MIPS pipeline. Drives the ENABLE inputs of the PC and of the IF_ID,
//  ID_EX, EX_MEM and MEM_WB stage registers, and the IF_ID flush and ID_EX bubble controls.

---
 rtl/mips_pkg.sv | 13 +
 rtl/hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline-control types and widths
package mips_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard between the load in EX and the instruction in ID
module hazard_detect #(
   parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rt_i,
   output logic                  load_use_o
);

   // $zero is never a real dependency, so a load targeting it cannot stall
   assign load_use_o = idex_memread_i && (idex_rt_i != '0) &&
                       ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer; PIPE_CTRL_CYCLE_CNT_EN adds a cycle counter
module pipeline_ctrl #(
   parameter int REG_ADDR_W   = mips_pkg::REG_ADDR_W,
   parameter int DRAIN_CYCLES = 3
`ifdef PIPE_CTRL_CYCLE_CNT_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  I_START,
   input  logic                  I_RUN_MODE,
   input  logic                  I_STEP,
   input  logic [REG_ADDR_W-1:0] I_ID_RS,
   input  logic [REG_ADDR_W-1:0] I_ID_RT,
   input  logic                  I_IDEX_MEMREAD,
   input  logic [REG_ADDR_W-1:0] I_IDEX_RT,
   input  logic                  I_BRANCH_TAKEN,
   input  logic                  I_HALT_ID,
   output logic                  O_PC_EN,
   output logic                  O_IFID_EN,
   output logic                  O_IDEX_EN,
   output logic                  O_EXMEM_EN,
   output logic                  O_MEMWB_EN,
   output logic                  O_IFID_FLUSH,
   output logic                  O_IDEX_BUBBLE,
   output logic                  O_DONE,
   output logic [2:0]            O_STATE
`ifdef PIPE_CTRL_CYCLE_CNT_EN
   ,
   output logic [CNT_W-1:0]      O_CYCLE_COUNT
`endif
);
   import mips_pkg::*;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_e        state_q, state_d;
   logic          mode_q, mode_d;
   logic          step_q;
   logic [DW-1:0] drain_q, drain_d;
   logic          load_use;
   logic          adv;

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .id_rs_i        (I_ID_RS),
      .id_rt_i        (I_ID_RT),
      .idex_memread_i (I_IDEX_MEMREAD),
      .idex_rt_i      (I_IDEX_RT),
      .load_use_o     (load_use)
   );

   // Single-step advances only on the rising edge of I_STEP
   assign adv = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                (mode_q || (I_STEP && !step_q));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         step_q  <= 1'b0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         step_q  <= I_STEP;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      drain_d       = drain_q;
      O_PC_EN       = 1'b0;
      O_IFID_EN     = 1'b0;
      O_IDEX_EN     = 1'b0;
      O_EXMEM_EN    = 1'b0;
      O_MEMWB_EN    = 1'b0;
      O_IFID_FLUSH  = 1'b0;
      O_IDEX_BUBBLE = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               state_d = ST_RUN;
               mode_d  = I_RUN_MODE;
            end
         end
         ST_RUN: begin
            if (adv) begin
               O_IDEX_EN  = 1'b1;
               O_EXMEM_EN = 1'b1;
               O_MEMWB_EN = 1'b1;
               if (load_use) begin
                  O_IDEX_BUBBLE = 1'b1;
               end else begin
                  O_PC_EN      = 1'b1;
                  O_IFID_EN    = 1'b1;
                  O_IFID_FLUSH = I_BRANCH_TAKEN;
                  if (I_HALT_ID) begin
                     state_d = ST_DRAIN;
                     drain_d = DW'(DRAIN_CYCLES - 1);
                  end
               end
            end
         end
         ST_DRAIN: begin
            // Fetch is frozen; bubbles push the in-flight instructions out
            if (adv) begin
               O_IDEX_EN     = 1'b1;
               O_EXMEM_EN    = 1'b1;
               O_MEMWB_EN    = 1'b1;
               O_IDEX_BUBBLE = 1'b1;
               if (drain_q == '0) state_d = ST_DONE;
               else               drain_d = drain_q - 1'b1;
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase
   end

   assign O_DONE  = (state_q == ST_DONE);
   assign O_STATE = state_q;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycle_q;

   always_ff @(posedge CLK) begin
      if (RESET)    cycle_q <= '0;
      else if (adv) cycle_q <= cycle_q + 1'b1;
   end

   assign O_CYCLE_COUNT = cycle_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

   localparam int DRAIN = 3;

   logic       clk = 1'b0;
   logic       rst, start, run_mode, step, memread, branch, halt;
   logic [4:0] rs, rt, idex_rt;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush, bubble, done;
   logic [2:0] state;
`ifdef PIPE_CTRL_CYCLE_CNT_EN
   logic [31:0] cycle_count;
`endif

   logic       n_rst, n_start, n_run_mode, n_step, n_memread, n_branch, n_halt;
   logic [4:0] n_rs, n_rt, n_idex_rt;

   int checks = 0;
   int failures = 0;

   int          m_state;
   bit          m_mode, m_prev_step;
   int          m_remaining;
   int unsigned m_count;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .CLK            (clk),
      .RESET          (rst),
      .I_START        (start),
      .I_RUN_MODE     (run_mode),
      .I_STEP         (step),
      .I_ID_RS        (rs),
      .I_ID_RT        (rt),
      .I_IDEX_MEMREAD (memread),
      .I_IDEX_RT      (idex_rt),
      .I_BRANCH_TAKEN (branch),
      .I_HALT_ID      (halt),
      .O_PC_EN        (pc_en),
      .O_IFID_EN      (ifid_en),
      .O_IDEX_EN      (idex_en),
      .O_EXMEM_EN     (exmem_en),
      .O_MEMWB_EN     (memwb_en),
      .O_IFID_FLUSH   (flush),
      .O_IDEX_BUBBLE  (bubble),
      .O_DONE         (done),
      .O_STATE        (state)
`ifdef PIPE_CTRL_CYCLE_CNT_EN
      ,
      .O_CYCLE_COUNT  (cycle_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] ens();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   endfunction

   // Model: compare this cycle's outputs, then move the model across the coming edge
   task automatic model_step();
      bit lu, adv;
      logic [4:0] e_en;
      bit e_flush, e_bubble;
      lu  = memread && (idex_rt != 0) && (idex_rt == rs || idex_rt == rt);
      adv = (m_state == 1 || m_state == 2) && (m_mode || (step && !m_prev_step));
      e_en = 5'b00000; e_flush = 0; e_bubble = 0;
      if (adv) begin
         if (m_state == 2 || lu) begin
            e_en = 5'b00111; e_bubble = 1;
         end else begin
            e_en = 5'b11111; e_flush = branch;
         end
      end
      chk("enables", 32'(ens()), 32'(e_en));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("bubble", 32'(bubble), 32'(e_bubble));
      chk("done", 32'(done), 32'(m_state == 3));
      chk("state", 32'(state), 32'(m_state));
`ifdef PIPE_CTRL_CYCLE_CNT_EN
      chk("cycle_count", cycle_count, m_count);
`endif
      if (rst) begin
         m_state = 0; m_mode = 0; m_prev_step = 0; m_remaining = 0; m_count = 0;
      end else begin
         m_prev_step = step;
         if (adv) m_count++;
         if (m_state == 0 && start) begin
            m_state = 1; m_mode = run_mode;
         end else if (m_state == 1 && adv && halt && !lu) begin
            m_state = 2; m_remaining = DRAIN;
         end else if (m_state == 2 && adv) begin
            m_remaining--;
            if (m_remaining == 0) m_state = 3;
         end
      end
   endtask

   task automatic apply();
      @(negedge clk);
      rst = n_rst; start = n_start; run_mode = n_run_mode; step = n_step;
      memread = n_memread; branch = n_branch; halt = n_halt;
      rs = n_rs; rt = n_rt; idex_rt = n_idex_rt;
      #2;
      model_step();
   endtask

   task automatic clear_inputs();
      n_rst = 0; n_start = 0; n_run_mode = 0; n_step = 0; n_memread = 0;
      n_branch = 0; n_halt = 0; n_rs = 0; n_rt = 0; n_idex_rt = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      n_rst = 1;
      apply();
      apply();
      n_rst = 0;
   endtask

   task automatic start_run(input bit mode);
      n_start = 1; n_run_mode = mode;
      apply();
      n_start = 0; n_run_mode = 0;
   endtask

   initial begin
      int adv_cnt;
      m_state = 0; m_mode = 0; m_prev_step = 0; m_remaining = 0; m_count = 0;
      clear_inputs();
      rst = 1; start = 0; run_mode = 0; step = 0; memread = 0; branch = 0; halt = 0;
      rs = 0; rt = 0; idex_rt = 0;

      do_reset();
      chk("reset_outputs", 32'({ens(), flush, bubble, done}), 32'h0);
      chk("reset_state", 32'(state), 32'd0);
      start_run(1);
      apply();
      chk("run_state", 32'(state), 32'd1);
      chk("run_enables", 32'(ens()), 32'h1f);

      n_memread = 1; n_idex_rt = 5; n_rs = 5;
      apply();
      chk("loaduse_enables", 32'(ens()), 32'h07);
      chk("loaduse_bubble", 32'(bubble), 32'd1);
      n_idex_rt = 0;
      apply();
      chk("rt0_no_stall", 32'(ens()), 32'h1f);
      n_memread = 0; n_rs = 0; n_branch = 1;
      apply();
      chk("branch_flush", 32'(flush), 32'd1);
      n_memread = 1; n_idex_rt = 5; n_rs = 5;
      apply();
      chk("branch_stall_flush", 32'(flush), 32'd0);
      chk("branch_stall_en", 32'(ens()), 32'h07);

      do_reset();
      start_run(0);
      adv_cnt = 0;
      n_step = 1;
      for (int i = 0; i < 5; i++) begin apply(); adv_cnt += int'(exmem_en); end
      n_step = 0; apply(); adv_cnt += int'(exmem_en);
      chk("held_step_advances", 32'(adv_cnt), 32'd1);
      adv_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         n_step = 1; apply(); adv_cnt += int'(exmem_en);
         n_step = 0; apply(); adv_cnt += int'(exmem_en);
      end
      chk("pulse_step_advances", 32'(adv_cnt), 32'd3);

      do_reset();
      start_run(1);
      n_halt = 1; apply(); n_halt = 0;
      for (int i = 0; i < DRAIN; i++) begin
         apply();
         chk("drain_state", 32'(state), 32'd2);
         chk("drain_enables", 32'(ens()), 32'h07);
      end
      n_start = 1;
      for (int i = 0; i < 10; i++) begin
         apply();
         chk("done_flag", 32'(done), 32'd1);
         chk("done_state", 32'(state), 32'd3);
      end
      n_start = 0;

      do_reset();
      start_run(1);
      n_halt = 1; apply(); n_halt = 0;
      apply();
      n_rst = 1; apply(); n_rst = 0;
      apply();
      chk("reset_in_drain_state", 32'(state), 32'd0);
      chk("reset_in_drain_done", 32'(done), 32'd0);

`ifdef PIPE_CTRL_CYCLE_CNT_EN
      do_reset();
      start_run(1);
      for (int i = 0; i < 10; i++) apply();
      apply();
      chk("cycle_count_10", cycle_count, 32'd10);
`endif

      do_reset();
      for (int i = 0; i < 4000; i++) begin
         n_rst      = ($urandom_range(0, 99) == 0);
         n_start    = ($urandom_range(0, 7) == 0);
         n_run_mode = 1'($urandom_range(0, 1));
         n_step     = 1'($urandom_range(0, 1));
         n_memread  = ($urandom_range(0, 2) == 0);
         n_branch   = ($urandom_range(0, 3) == 0);
         n_halt     = ($urandom_range(0, 15) == 0);
         n_rs       = 5'($urandom_range(0, 3));
         n_rt       = 5'($urandom_range(0, 3));
         n_idex_rt  = 5'($urandom_range(0, 3));
         apply();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
